seg_scan_decoder: RTL

//  Receive-side counterpart of the 7-segment display driver: snoops a multiplexed

---
 rtl/seg_scan_pkg.sv | 42 ++++
 rtl/seg_scan_decoder_seg7_to_bin.sv | 45 ++++
 rtl/seg_scan_decoder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_pkg
//  Description : Shared definitions for the 7-segment scan decoder: active-low
//                segment patterns (gfedcba) for 0-F, error codes and the FSM
//                state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] c_seg_0 = 7'b1000000;
    localparam logic [6:0] c_seg_1 = 7'b1111001;
    localparam logic [6:0] c_seg_2 = 7'b0100100;
    localparam logic [6:0] c_seg_3 = 7'b0110000;
    localparam logic [6:0] c_seg_4 = 7'b0011001;
    localparam logic [6:0] c_seg_5 = 7'b0010010;
    localparam logic [6:0] c_seg_6 = 7'b0000010;
    localparam logic [6:0] c_seg_7 = 7'b1111000;
    localparam logic [6:0] c_seg_8 = 7'b0000000;
    localparam logic [6:0] c_seg_9 = 7'b0010000;
    localparam logic [6:0] c_seg_a = 7'b0001000;
    localparam logic [6:0] c_seg_b = 7'b0000011;
    localparam logic [6:0] c_seg_c = 7'b1000110;
    localparam logic [6:0] c_seg_d = 7'b0100001;
    localparam logic [6:0] c_seg_e = 7'b0000110;
    localparam logic [6:0] c_seg_f = 7'b0001110;

    // err_code values
    localparam logic [1:0] c_err_none      = 2'd0;
    localparam logic [1:0] c_err_bad_seg   = 2'd1;
    localparam logic [1:0] c_err_multi_sel = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seg_scan_decoder_seg7_to_bin.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_to_bin
//  Description : Combinational active-low 7-segment pattern to binary decode.
//                Ports: seg[6:0] in (gfedcba, active-low), legal out, value[3:0]
//                out (0 when illegal).
//                Build option SEG_HEX_EN: also accept the A,b,C,d,E,F glyphs.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_to_bin
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] value
);

    always_comb begin
        legal = 1'b1;
        value = 4'd0;
        case (seg)
            c_seg_0: value = 4'd0;
            c_seg_1: value = 4'd1;
            c_seg_2: value = 4'd2;
            c_seg_3: value = 4'd3;
            c_seg_4: value = 4'd4;
            c_seg_5: value = 4'd5;
            c_seg_6: value = 4'd6;
            c_seg_7: value = 4'd7;
            c_seg_8: value = 4'd8;
            c_seg_9: value = 4'd9;
`ifdef SEG_HEX_EN
            c_seg_a: value = 4'd10;
            c_seg_b: value = 4'd11;
            c_seg_c: value = 4'd12;
            c_seg_d: value = 4'd13;
            c_seg_e: value = 4'd14;
            c_seg_f: value = 4'd15;
`endif
            default: legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_decoder
//  Description : Snoops a multiplexed active-low digit-select / segment bus and
//                rebuilds the per-digit 4-bit values. Each scan slot must be
//                stable for STABLE_CYCLES samples before one capture is taken.
//  Ports       : clk, rst_n (async, active-low)
//                sel_in[NUM_DIGITS-1:0]  digit select, active-low
//                seg_in[6:0]             segments, active-low, gfedcba
//                digits_out              digit i at [4i+3:4i]
//                digit_valid             slot i holds a legal capture
//                frame_done              1-cycle pulse, all digits seen
//                err / err_code          reject pulse / sticky reason code
//  Build option: SEG_HEX_EN - accept hex glyphs A..F (decoded in seg7_to_bin).
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   sel_in,
    input  logic [6:0]              seg_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    err,
    output logic [1:0]              err_code
);

    // Counter saturates at STABLE_CYCLES so a long hold never looks like a
    // fresh window.
    localparam int                c_cnt_w    = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(STABLE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_fire = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [NUM_DIGITS-1:0] c_sel_one = NUM_DIGITS'(1);

    logic [NUM_DIGITS-1:0]   r_sel;
    logic [6:0]              r_seg;
    logic [c_cnt_w-1:0]      r_cnt;
    state_t                  r_state;
    state_t                  w_next;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic                    r_fd;
    logic                    r_err;
    logic [1:0]              r_code;

    logic                    w_same;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_low;
    logic                    w_one;
    logic                    w_cap;
    logic                    w_cap_single;
    logic                    w_err_bad;
    logic                    w_err_multi;
    logic [NUM_DIGITS-1:0]   w_seen_set;
    logic                    w_legal;
    logic [3:0]              w_value;

    // The live pins are compared against the registered sample, so the count
    // already reflects the sample about to be registered; this gives a
    // pin-to-output latency of STABLE_CYCLES+1 clocks.
    assign w_same  = ({sel_in, seg_in} == {r_sel, r_seg});
    assign w_blank = &r_sel;
    assign w_low   = ~r_sel;

    // -------------------------------------------------------------------------
    // Input sample register and stability counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= '1;
            r_seg <= '1;
            r_cnt <= '0;
        end else begin
            r_sel <= sel_in;
            r_seg <= seg_in;
            if (!w_same) begin
                r_cnt <= '0;
            end else if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state. r_cnt == 0 marks a sample that differs from the one
    // before it, i.e. the start of a new window. CAPTURE also checks for it so
    // a change landing right on the capture edge is not missed.
    // -------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_blank) w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_blank)                  w_next = ST_IDLE;
                else if (r_cnt == c_cnt_fire) w_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (w_blank)           w_next = ST_IDLE;
                else if (r_cnt == '0)  w_next = ST_SETTLE;
                else                   w_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_blank)           w_next = ST_IDLE;
                else if (r_cnt == '0)  w_next = ST_SETTLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs. The capture is taken on the SETTLE -> CAPTURE edge.
    // -------------------------------------------------------------------------
    always_comb begin
        w_one        = (w_low != '0) && ((w_low & (w_low - c_sel_one)) == '0);
        w_cap        = (r_state == ST_SETTLE) && !w_blank && (r_cnt == c_cnt_fire);
        w_cap_single = w_cap && w_one;
        w_err_bad    = w_cap_single && !w_legal;
        w_err_multi  = w_cap && !w_one;
        w_seen_set   = (w_cap_single && w_legal) ? w_low : '0;
    end

    seg7_to_bin u_dec (
        .seg   (r_seg),
        .legal (w_legal),
        .value (w_value)
    );

    // -------------------------------------------------------------------------
    // Digit storage, seen mask, frame and error flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= '0;
            r_valid  <= '0;
            r_seen   <= '0;
            r_fd     <= 1'b0;
            r_err    <= 1'b0;
            r_code   <= c_err_none;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_cap_single && w_low[i]) begin
                    if (w_legal) begin
                        r_digits[4*i +: 4] <= w_value;
                        r_valid[i]         <= 1'b1;
                    end else begin
                        r_valid[i]         <= 1'b0;
                    end
                end
            end
            // A full mask is reported and cleared one cycle after it fills.
            r_fd   <= &r_seen;
            r_seen <= ((&r_seen) ? '0 : r_seen) | w_seen_set;
            r_err  <= w_err_bad || w_err_multi;
            if (w_err_multi) begin
                r_code <= c_err_multi_sel;
            end else if (w_err_bad) begin
                r_code <= c_err_bad_seg;
            end
        end
    end

    assign digits_out  = r_digits;
    assign digit_valid = r_valid;
    assign frame_done  = r_fd;
    assign err         = r_err;
    assign err_code    = r_code;

endmodule
`default_nettype wire
